dmem_bridge: RTL

Data-side bridge between the core's load/store port and a word-addressed data memory with a request/grant/response handshake. It captures a single-cycle load or store request from the core, steers byte lanes by address offset, and runs the memory handshake. It returns right-justified load data and holds `stall` high until the access completes. It sits directly downstream of the core's `write_en`/`read_en`/`byte_en`/`addr`/`write_data` outputs and drives the core's `read_data` input.

---
 rtl/dmem_bridge_pkg.sv | 21 ++
 rtl/dmem_bridge_lane_steer.sv | 26 ++
 rtl/dmem_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared types and constants for the data-memory bridge
package typePack;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } dmem_state_t;

  localparam logic [3:0]  BE_BYTE = 4'b0001;
  localparam logic [3:0]  BE_HALF = 4'b0011;
  localparam logic [3:0]  BE_WORD = 4'b1111;

  localparam logic [31:0] DMEM_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Expands a right-justified size mask into a byte-granular data mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dmem_bridge_lane_steer.sv
// rtl/dmem_bridge_lane_steer.sv - byte-lane steering for stores and loads, plus alignment check
module dmem_lane_steer
  import typePack::*;
(
  input  logic [1:0]  off,
  input  logic [3:0]  byte_en,
  input  logic [31:0] write_data,
  input  logic [1:0]  ld_off,
  input  logic [3:0]  ld_be,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be_steered,
  output logic [31:0] wdata_steered,
  output logic [31:0] rdata_aligned,
  output logic        misaligned
);

  assign be_steered    = byte_en << off;
  assign wdata_steered = write_data << {off, 3'b000};

  // Load side uses the offset/size captured with the request, not the live core inputs.
  assign rdata_aligned = (mem_rdata >> {ld_off, 3'b000}) & be_to_mask(ld_be);

  assign misaligned = ((byte_en == BE_HALF) && off[0]) ||
                      ((byte_en == BE_WORD) && (off != 2'b00));

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - core load/store to request/grant/response memory bridge
// Optional watchdog enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
  import typePack::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misalign_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  dmem_state_t state, next_state;

  logic [1:0]  ld_off;
  logic [3:0]  ld_be;
  logic [3:0]  be_steered;
  logic [31:0] wdata_steered;
  logic [31:0] rdata_aligned;
  logic        misaligned;
  logic        accept;
  logic        req_err;
  logic        timeout;

  dmem_lane_steer u_lane_steer (
    .off           (addr[1:0]),
    .byte_en       (byte_en),
    .write_data    (write_data),
    .ld_off        (ld_off),
    .ld_be         (ld_be),
    .mem_rdata     (mem_rdata),
    .be_steered    (be_steered),
    .wdata_steered (wdata_steered),
    .rdata_aligned (rdata_aligned),
    .misaligned    (misaligned)
  );

  assign stall = (state != IDLE);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
    end else if ((state == IDLE) || (state != next_state)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the last permitted cycle so the FSM is in IDLE after exactly TIMEOUT_CYCLES.
  assign timeout = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req_err    = 1'b0;
    case (state)
      IDLE: begin
        if (read_en && write_en) begin
          req_err = 1'b1;
        end else if (read_en || write_en) begin
          if (misaligned) begin
            req_err = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          next_state = IDLE;
        end else if (mem_gnt) begin
          next_state = mem_we ? IDLE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (timeout || mem_rvalid) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      read_data    <= '0;
      misalign_err <= 1'b0;
      ld_off       <= '0;
      ld_be        <= '0;
    end else begin
      misalign_err <= req_err | timeout;

      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= write_en;
        mem_be    <= be_steered;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdata_steered;
        ld_off    <= addr[1:0];
        ld_be     <= byte_en;
      end else if ((state == REQ) && (mem_gnt || timeout)) begin
        mem_req <= 1'b0;
      end

      if (timeout && !mem_we) begin
        read_data <= DMEM_TIMEOUT_DATA;
      end else if ((state == WAIT_R) && mem_rvalid) begin
        read_data <= rdata_aligned;
      end
    end
  end

endmodule
